// File: rtl/bus_compare_ctrl_if.sv
// Bus bundle for bus_compare_ctrl: two redundant channel samples with strobes,
// fault clear, and the relay/heartbeat/status outputs.
// Optional CMP_STATS_EN adds the cmpCount/errCount statistic outputs.
interface bus_compare_ctrl_if #(
    parameter int BUS_W = 16
);
    logic [BUS_W-1:0] busA;
    logic             busAValid;
    logic [BUS_W-1:0] busB;
    logic             busBValid;
    logic             clearFault;
    logic             relayCtrl1;
    logic             relayCtrl2;
    logic             switchCtrl1;
    logic             switchCtrl2;
    logic             faultFlag;
    logic [3:0]       misCnt;
`ifdef CMP_STATS_EN
    logic [15:0]      cmpCount;
    logic [15:0]      errCount;

    modport master (
        output busA, busAValid, busB, busBValid, clearFault,
        input  relayCtrl1, relayCtrl2, switchCtrl1, switchCtrl2, faultFlag, misCnt,
        input  cmpCount, errCount
    );

    modport slave (
        input  busA, busAValid, busB, busBValid, clearFault,
        output relayCtrl1, relayCtrl2, switchCtrl1, switchCtrl2, faultFlag, misCnt,
        output cmpCount, errCount
    );
`else
    modport master (
        output busA, busAValid, busB, busBValid, clearFault,
        input  relayCtrl1, relayCtrl2, switchCtrl1, switchCtrl2, faultFlag, misCnt
    );

    modport slave (
        input  busA, busAValid, busB, busBValid, clearFault,
        output relayCtrl1, relayCtrl2, switchCtrl1, switchCtrl2, faultFlag, misCnt
    );
`endif
endinterface

// File: rtl/bus_compare_ctrl.sv
// Dual-channel bus compare controller. Captures the A/B samples, compares them,
// and drives relay levels plus heartbeat; persistent disagreement or a missing
// channel latches FAULT, disabling the relay and freezing the heartbeat.
// Optional CMP_STATS_EN adds saturating compare/error counters.
module bus_compare_ctrl #(
    parameter int BUS_W     = 16,
    parameter int HB_PERIOD = 16,
    parameter int HB_HIGH   = 2,
    parameter int MIS_LIMIT = 3,
    parameter int TIMEOUT   = 8
) (
    input logic           clk,
    input logic           rstN,
    bus_compare_ctrl_if.slave bus
);
    localparam int HB_W = (HB_PERIOD > 1) ? $clog2(HB_PERIOD) : 1;
    localparam logic [HB_W-1:0] HB_LAST = HB_W'(HB_PERIOD - 1);
    localparam logic [HB_W-1:0] HB_ON   = HB_W'(HB_HIGH);
    localparam logic [7:0]      TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [3:0]      MIS_MAX  = 4'(MIS_LIMIT);

    typedef enum logic [2:0] {IDLE, WAIT_A, WAIT_B, CMP, FAULT} state_t;

    state_t           state;
    state_t           stateNext;
    logic [BUS_W-1:0] capA;
    logic [BUS_W-1:0] capB;
    logic [7:0]       tmr;
    logic             tmoFail;
    logic             timeoutHit;
    logic             pass;
    logic [3:0]       misCnt;
    logic [3:0]       misInc;
    logic             armed;
    logic             run;
    logic [HB_W-1:0]  hbCnt;
    logic             collecting;
    logic             waiting;

    assign collecting = (state == IDLE) || (state == WAIT_A) || (state == WAIT_B);
    assign waiting    = (state == WAIT_A) || (state == WAIT_B);
    assign run        = armed && (state != FAULT);

    // State register
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) state <= IDLE;
        else       state <= stateNext;
    end

    // Next-state decode plus compare verdict and timeout detection
    always_comb begin
        stateNext  = state;
        timeoutHit = 1'b0;
        pass       = (capA == capB) && !tmoFail;
        misInc     = (misCnt == 4'hF) ? 4'hF : misCnt + 4'd1;
        case (state)
            IDLE: begin
                if (bus.busAValid && bus.busBValid) stateNext = CMP;
                else if (bus.busAValid)             stateNext = WAIT_B;
                else if (bus.busBValid)             stateNext = WAIT_A;
            end
            WAIT_B: begin
                if (bus.busBValid) stateNext = CMP;
                else if (tmr == TMO_LAST) begin
                    stateNext  = CMP;
                    timeoutHit = 1'b1;
                end
            end
            WAIT_A: begin
                if (bus.busAValid) stateNext = CMP;
                else if (tmr == TMO_LAST) begin
                    stateNext  = CMP;
                    timeoutHit = 1'b1;
                end
            end
            CMP: begin
                if (!pass && (misInc >= MIS_MAX)) stateNext = FAULT;
                else                              stateNext = IDLE;
            end
            FAULT: begin
                if (bus.clearFault) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Sample capture, wait timer, and compare result bookkeeping
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            capA    <= '0;
            capB    <= '0;
            tmr     <= '0;
            tmoFail <= 1'b0;
            misCnt  <= '0;
            armed   <= 1'b0;
        end else begin
            // A repeat strobe on the side already held simply overwrites it;
            // the timer keeps running because it only resets outside WAIT_x.
            if (collecting && bus.busAValid) capA <= bus.busA;
            if (collecting && bus.busBValid) capB <= bus.busB;
            tmr     <= waiting ? tmr + 8'd1 : '0;
            tmoFail <= timeoutHit;
            if (state == CMP) begin
                if (pass) begin
                    misCnt <= '0;
                    armed  <= 1'b1;
                end else begin
                    misCnt <= misInc;
                    if (misInc >= MIS_MAX) armed <= 1'b0;
                end
            end else if (state == FAULT && bus.clearFault) begin
                misCnt <= '0;
            end
        end
    end

    // Heartbeat counter, held at zero whenever the relay is not enabled
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)                hbCnt <= '0;
        else if (!run)            hbCnt <= '0;
        else if (hbCnt == HB_LAST) hbCnt <= '0;
        else                      hbCnt <= hbCnt + 1'b1;
    end

`ifdef CMP_STATS_EN
    logic [15:0] cmpCount;
    logic [15:0] errCount;

    // Saturating compare/error statistics, cleared with the fault
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cmpCount <= '0;
            errCount <= '0;
        end else if (state == CMP) begin
            if (cmpCount != '1) cmpCount <= cmpCount + 16'd1;
            if (!pass && errCount != '1) errCount <= errCount + 16'd1;
        end else if (state == FAULT && bus.clearFault) begin
            cmpCount <= '0;
            errCount <= '0;
        end
    end

    assign bus.cmpCount = cmpCount;
    assign bus.errCount = errCount;
`endif

    assign bus.relayCtrl1  = 1'b1;
    assign bus.relayCtrl2  = run;
    assign bus.switchCtrl1 = run ? (hbCnt < HB_ON) : 1'b1;
    assign bus.switchCtrl2 = run ? !(hbCnt < HB_ON) : 1'b0;
    assign bus.faultFlag   = (state == FAULT);
    assign bus.misCnt      = misCnt;
endmodule

// File: tb/tb_bus_compare_ctrl.sv
// Self-checking bench for bus_compare_ctrl: directed vector table, hand-written
// corner sequences, then random strobes against a behavioural model.
module tb_bus_compare_ctrl;
    localparam int TIMEOUT   = 8;
    localparam int MIS_LIMIT = 3;
    localparam int HB_PERIOD = 16;
    localparam int HB_HIGH   = 2;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    int   nCmp = 0;
    int   nFail = 0;

    always #5 clk = ~clk;

    bus_compare_ctrl_if #(.BUS_W(16)) bif ();

    bus_compare_ctrl #(
        .BUS_W(16), .HB_PERIOD(HB_PERIOD), .HB_HIGH(HB_HIGH),
        .MIS_LIMIT(MIS_LIMIT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rstN(rstN),
        .bus(bif.slave)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        int          expMis;
        bit          expFault;
        bit          expRelay;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        nCmp++;
        if (act != exp) begin
            nFail++;
            if (nFail < 30) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOut(input string tag, input int mis, input bit flt, input bit rel);
        check({tag, ".misCnt"}, int'(bif.misCnt), mis);
        check({tag, ".faultFlag"}, int'(bif.faultFlag), int'(flt));
        check({tag, ".relayCtrl2"}, int'(bif.relayCtrl2), int'(rel));
        check({tag, ".relayCtrl1"}, int'(bif.relayCtrl1), 1);
    endtask

    task automatic sendPair(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        bif.busA = a; bif.busB = b; bif.busAValid = 1'b1; bif.busBValid = 1'b1;
        @(negedge clk);
        bif.busAValid = 1'b0; bif.busBValid = 1'b0;
        @(negedge clk);
    endtask

    // Behavioural reference: sample holding, verdicts, fault and heartbeat phase
    bit          mHaveA, mHaveB, mDue, mPass, mFault, mArmed;
    logic [15:0] mA, mB;
    int          mAge, mMiss, mPhase, mCmps, mErrs;

    function automatic void modelReset();
        mHaveA = 0; mHaveB = 0; mDue = 0; mPass = 0; mFault = 0; mArmed = 0;
        mA = '0; mB = '0; mAge = 0; mMiss = 0; mPhase = 0; mCmps = 0; mErrs = 0;
    endfunction

    function automatic void modelStep(input bit vA, input logic [15:0] a,
                                      input bit vB, input logic [15:0] b, input bit clr);
        bit wasWaiting;
        mPhase = (mArmed && !mFault) ? (mPhase + 1) % HB_PERIOD : 0;
        if (mFault) begin
            if (clr) begin
                mFault = 0; mMiss = 0; mCmps = 0; mErrs = 0;
            end
        end else if (mDue) begin
            if (mCmps < 65535) mCmps++;
            if (mPass) begin
                mMiss = 0; mArmed = 1;
            end else begin
                if (mErrs < 65535) mErrs++;
                mMiss = (mMiss < 15) ? mMiss + 1 : 15;
                if (mMiss >= MIS_LIMIT) begin
                    mFault = 1; mArmed = 0;
                end
            end
            mDue = 0;
        end else begin
            wasWaiting = mHaveA ^ mHaveB;
            if (vA) begin mA = a; mHaveA = 1; end
            if (vB) begin mB = b; mHaveB = 1; end
            if (mHaveA && mHaveB) begin
                mDue = 1; mPass = (mA == mB); mHaveA = 0; mHaveB = 0;
            end else if (mHaveA || mHaveB) begin
                if (wasWaiting) begin
                    mAge++;
                    if (mAge == TIMEOUT) begin
                        mDue = 1; mPass = 0; mHaveA = 0; mHaveB = 0;
                    end
                end else begin
                    mAge = 0;
                end
            end
        end
    endfunction

    initial begin
        bit run;
        bit vA, vB, clr;
        logic [15:0] a, b;
        int pv;

        vecs[0] = '{16'h5A5A, 16'h5A5A, 0, 0, 1};
        vecs[1] = '{16'h0001, 16'h0002, 1, 0, 1};
        vecs[2] = '{16'h0001, 16'h0002, 2, 0, 1};
        vecs[3] = '{16'h1234, 16'h1234, 0, 0, 1};
        vecs[4] = '{16'h0001, 16'h0002, 1, 0, 1};
        vecs[5] = '{16'h0001, 16'h0002, 2, 0, 1};
        vecs[6] = '{16'h0001, 16'h0002, 3, 1, 0};

        bif.busA = '0; bif.busB = '0; bif.busAValid = 0; bif.busBValid = 0; bif.clearFault = 0;
        #12;
        checkOut("reset", 0, 0, 0);
        check("reset.sw1", int'(bif.switchCtrl1), 1);
        check("reset.sw2", int'(bif.switchCtrl2), 0);
        @(negedge clk);
        rstN = 1'b1;

        for (int i = 0; i < 7; i++) begin
            sendPair(vecs[i].a, vecs[i].b);
            checkOut($sformatf("vec%0d", i), vecs[i].expMis, vecs[i].expFault, vecs[i].expRelay);
            if (i == 0) begin
                for (int k = 0; k < 2 * HB_PERIOD; k++) begin
                    check($sformatf("hb.sw1[%0d]", k), int'(bif.switchCtrl1), int'((k % HB_PERIOD) < HB_HIGH));
                    check($sformatf("hb.sw2[%0d]", k), int'(bif.switchCtrl2), int'((k % HB_PERIOD) >= HB_HIGH));
                    @(negedge clk);
                end
            end
        end
        check("fault.sw1", int'(bif.switchCtrl1), 1);
        check("fault.sw2", int'(bif.switchCtrl2), 0);

        // Strobes in FAULT are dropped; clearFault releases but relay stays off
        sendPair(16'h0005, 16'h0005);
        checkOut("faultDrop", 3, 1, 0);
        bif.clearFault = 1'b1;
        @(negedge clk);
        bif.clearFault = 1'b0;
        checkOut("cleared", 0, 0, 0);
        repeat (3) @(negedge clk);
        checkOut("clearedIdle", 0, 0, 0);
        check("cleared.sw1", int'(bif.switchCtrl1), 1);
        bif.busA = 16'h0007; bif.busB = 16'h0007; bif.busAValid = 1; bif.busBValid = 1;
        @(negedge clk);
        bif.busAValid = 0; bif.busBValid = 0;
        checkOut("rearm1clk", 0, 0, 0);
        @(negedge clk);
        checkOut("rearm2clk", 0, 0, 1);

        // Channel B missing: timeout-fail after TIMEOUT waiting cycles
        bif.busA = 16'h0009; bif.busAValid = 1;
        @(negedge clk);
        bif.busAValid = 0;
        repeat (TIMEOUT) @(negedge clk);
        checkOut("tmoBefore", 0, 0, 1);
        @(negedge clk);
        checkOut("tmoAfter", 1, 0, 1);

        // Reset while holding A discards it; B alone must then wait for A
        bif.busA = 16'h1111; bif.busAValid = 1;
        @(negedge clk);
        bif.busAValid = 0;
        #2 rstN = 1'b0;
        #1;
        checkOut("midReset", 0, 0, 0);
        check("midReset.sw1", int'(bif.switchCtrl1), 1);
        check("midReset.sw2", int'(bif.switchCtrl2), 0);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        bif.busB = 16'h2222; bif.busBValid = 1;
        @(negedge clk);
        bif.busBValid = 0;
        @(negedge clk);
        checkOut("noStale", 0, 0, 0);
        repeat (TIMEOUT) @(negedge clk);
        checkOut("waitATmo", 1, 0, 0);

        // Randomized phase against the reference model
        @(negedge clk);
        rstN = 1'b0;
        modelReset();
        @(negedge clk);
        rstN = 1'b1;
        pv = 30;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            run = mArmed && !mFault;
            check("rnd.misCnt", int'(bif.misCnt), mMiss);
            check("rnd.faultFlag", int'(bif.faultFlag), int'(mFault));
            check("rnd.relayCtrl2", int'(bif.relayCtrl2), int'(run));
            check("rnd.sw1", int'(bif.switchCtrl1), run ? int'(mPhase < HB_HIGH) : 1);
            check("rnd.sw2", int'(bif.switchCtrl2), run ? int'(mPhase >= HB_HIGH) : 0);
`ifdef CMP_STATS_EN
            check("rnd.cmpCount", int'(bif.cmpCount), mCmps);
            check("rnd.errCount", int'(bif.errCount), mErrs);
`endif
            if (cyc % 200 == 0) pv = int'($urandom_range(5, 45));
            vA  = ($urandom_range(0, 99) < pv);
            vB  = ($urandom_range(0, 99) < pv);
            clr = ($urandom_range(0, 99) < 8);
            a   = 16'($urandom_range(0, 3));
            b   = 16'($urandom_range(0, 3));
            bif.busA = a; bif.busB = b; bif.busAValid = vA; bif.busBValid = vB; bif.clearFault = clr;
            modelStep(vA, a, vB, b, clr);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end
endmodule
